// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler for 7 requesters sharing one downstream resource.
// Grants are held until done, request withdrawal, or a MAX_HOLD timeout.
module rr_grant_scheduler #(
  parameter bit          USE_GRAY = 1'b1,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] req,
  input  logic       done,
  output logic [6:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [2:0] gnt_code,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr;
  logic [7:0] cnt;
  logic [2:0] sel;
  logic       found;
  logic [3:0] cand;
  logic       load;
  logic       release_now;
  logic       hold_exp;
  logic       timeout_nxt;

  // Rotating priority scan starting just after the last granted requester.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    cand  = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (!found && req[cand[2:0]]) begin
        sel   = cand[2:0];
        found = 1'b1;
      end
    end
  end

  assign hold_exp = (cnt == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    release_now = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (done || !req[ptr] || hold_exp) begin
          release_now = 1'b1;
          state_nxt   = IDLE;
          // Timeout is flagged only when the counter alone forced the release.
          timeout_nxt = hold_exp && !done && req[ptr];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd6;
      cnt      <= 8'd0;
      gnt      <= 7'd0;
      gnt_idx  <= 3'd0;
      gnt_code <= 3'd0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timeout <= timeout_nxt;
      if (load) begin
        gnt      <= 7'(1) << sel;
        gnt_idx  <= sel;
        gnt_code <= USE_GRAY ? (sel ^ (sel >> 1)) : sel;
        ptr      <= sel;
        cnt      <= 8'd0;
      end else if (release_now) begin
        gnt      <= 7'd0;
        gnt_idx  <= 3'd0;
        gnt_code <= 3'd0;
        cnt      <= 8'd0;
      end else if (state == GRANT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one downstream resource among 7 requesters.
- Issues a registered one-hot grant and a 3-bit encoded grant index. The index is Gray-coded or binary, selected by parameter, so it can drive code-selected datapaths directly.
- Grant is held until the owner signals done, withdraws its request, or a hold-timeout expires.
- Sits between requester ports and the shared encoder/datapath resource.

Parameters:
- USE_GRAY, 1, 1: gnt_code is the Gray code of the granted index; 0: gnt_code is plain binary.
- MAX_HOLD, 15, maximum cycles a grant may be held before forced release; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  7  request vector; bit i asserted = requester i wants the resource.
- done  input  1  current owner finished; sampled only in GRANT state.
- gnt  output  7  one-hot grant (registered); all zero when idle.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.
- gnt_idx  output  3  binary index of the granted requester; 0 when idle.
- gnt_code  output  3  encoded index per USE_GRAY (Gray: 0→000, 1→001, 2→011, 3→010, 4→110, 5→111, 6→101); 000 when idle.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst high at a clock edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, gnt_code=0, timeout=0.
  - State=IDLE, last-grant pointer ptr=6 (so requester 0 has first priority), hold counter=0.
  - Reset mid-grant drops the grant on that edge; no done is required.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit scanning ptr+1, ptr+2, … with wrap 6→0.
  - Next edge: gnt=onehot(sel), gnt_idx=sel, gnt_code=enc(sel), ptr=sel, counter=0, go to GRANT.
  - If req == 0, stay in IDLE with outputs at zero.
  - Latency: request visible at edge k → grant visible after edge k (1 cycle).
- GRANT:
  - Counter increments each cycle.
  - Release condition: done=1, OR req[ptr]=0 (withdrawal), OR counter==MAX_HOLD-1.
  - On release, next edge: outputs go to zero, go to IDLE.
  - timeout=1 for exactly that one cycle only when release was caused solely by the counter. done or withdrawal on the same cycle take priority and suppress the timeout pulse.
  - No other requester may preempt a grant.
- Back-to-back: minimum one idle cycle (gnt=0) between consecutive grants, including re-grant of the same requester.
- Fairness: a requester that holds req continuously is granted within 6 grant periods.
- req bits for non-owners may change freely during GRANT; they are sampled only in IDLE.
- done while in IDLE is ignored.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset then req=7'b0000001 → after 1 edge gnt=0000001, gnt_idx=0, gnt_code=000; assert done for 1 cycle → gnt=0 next edge.
- req=7'b1111111 held, done pulsed once per grant → grant order is 0,1,2,3,4,5,6,0. Each grant is separated by one idle cycle. With USE_GRAY=1, gnt_code sequence is 000,001,011,010,110,111,101,000.
- MAX_HOLD=4, req=7'b0001000, done never asserted → gnt=0001000 for 4 cycles, then timeout pulse=1 for one cycle with gnt=0. Re-grant of index 3 follows the next cycle.
- Granted requester 5 drops req[5] mid-grant while req[2]=1 → grant releases next edge with timeout=0, then index 2 is granted (wrap from ptr=5).
- rst asserted while gnt=0100000 → all outputs 0 on that edge. After release of rst with req=7'b1000001, requester 0 is granted first (ptr restored to 6).
- USE_GRAY=0 build, req=7'b1000000 → gnt_idx=6, gnt_code=110; done and timeout coinciding on the last hold cycle → timeout stays 0.
